// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch display scanner: slot index type,
// scan state encoding and the 7-segment pattern for digit zero.
package cronometro_pkg;

  localparam logic [6:0] SEG_ZERO = 7'h3F;

  typedef logic [1:0] slot_idx_t;

  typedef enum logic [0:0] {
    SCAN_BLANK = 1'b0,
    SCAN_ON    = 1'b1
  } scan_state_t;

  // One-hot digit enable for a slot index
  function automatic logic [3:0] slot_onehot(input slot_idx_t idx);
    logic [3:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-slot timing: a cycle counter that walks through the blanking gap
// and the lit portion of one digit slot, then restarts for the next slot.
module scan_slot_timer
  import cronometro_pkg::*;
#(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  output scan_state_t state,
  output logic        slot_start,
  output logic        slot_done
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);

  logic [CW-1:0] cyc_cnt;

  assign slot_start = (state == SCAN_BLANK) && (cyc_cnt == '0);
  assign slot_done  = (state == SCAN_ON) && (cyc_cnt == SLOT_LAST);

  // Count through BLANK then ON; the terminal ON cycle wraps back to BLANK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SCAN_BLANK;
      cyc_cnt <= '0;
    end else if (slot_done) begin
      state   <= SCAN_BLANK;
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if ((state == SCAN_BLANK) && (cyc_cnt == BLANK_LAST))
        state <= SCAN_ON;
    end
  end

endmodule

// File: rtl/cronometro_display_scan.sv
// Time-multiplexes the four stopwatch digits onto one segment bus with
// blanking gaps between digits, a per-slot snapshot of the digit pattern,
// optional minutes-tens leading-zero suppression and a blinking separator.
module cronometro_display_scan
  import cronometro_pkg::*;
#(
  parameter int SLOT_CYC    = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int BLINK_SLOTS = 400,
  parameter bit ACT_LOW     = 1'b1
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic [6:0] seg_su,
  input  logic [6:0] seg_st,
  input  logic [6:0] seg_mu,
  input  logic [6:0] seg_mt,
  input  logic       run,
  input  logic       lz_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame
);

  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);
  localparam logic [6:0] SEG_INV = ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_INV  = ACT_LOW ? 4'hF : 4'h0;
  localparam logic       DP_INV  = ACT_LOW;

  scan_state_t   state;
  logic          slot_start;
  logic          slot_done;
  slot_idx_t     slot;
  logic [6:0]    slot_pattern;
  logic [6:0]    snap;
  logic [BW-1:0] blink_cnt;
  logic          phase_lit;
  logic          lz_hide;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  scan_slot_timer #(
    .SLOT_CYC  (SLOT_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (CLK_IN),
    .rst        (RST),
    .state      (state),
    .slot_start (slot_start),
    .slot_done  (slot_done)
  );

  // Advance to the next digit at the end of every slot, wrapping after mt
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) slot <= 2'd0;
    else if (slot_done) slot <= slot + 2'd1;
  end

  // Select the incoming pattern belonging to the current slot
  always_comb begin
    slot_pattern = seg_su;
    case (slot)
      2'd0: slot_pattern = seg_su;
      2'd1: slot_pattern = seg_st;
      2'd2: slot_pattern = seg_mu;
      2'd3: slot_pattern = seg_mt;
      default: slot_pattern = seg_su;
    endcase
  end

  // Freeze the digit pattern at slot start so mid-slot changes cannot tear
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) snap <= '0;
    else if (slot_start) snap <= slot_pattern;
  end

  // Separator phase: toggles every BLINK_SLOTS finished slots while running,
  // and is held lit with a cleared count while stopped
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      blink_cnt <= '0;
      phase_lit <= 1'b1;
    end else if (!run) begin
      blink_cnt <= '0;
      phase_lit <= 1'b1;
    end else if (slot_done) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase_lit <= ~phase_lit;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Active-high pin values for the next cycle, derived from the scan state
  always_comb begin
    lz_hide = lz_en && (slot == 2'd3) && (snap == SEG_ZERO);
    an_nxt  = 4'b0000;
    seg_nxt = 7'h00;
    dp_nxt  = 1'b0;
    if (state == SCAN_ON) begin
      seg_nxt = snap;
      if (!lz_hide) an_nxt = slot_onehot(slot);
      dp_nxt  = (slot == 2'd2) && phase_lit;
    end
  end

  // Output register; pin polarity is applied only here
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      seg   <= SEG_INV;
      dp    <= DP_INV;
      an    <= AN_INV;
      frame <= 1'b0;
    end else begin
      seg   <= seg_nxt ^ SEG_INV;
      dp    <= dp_nxt ^ DP_INV;
      an    <= an_nxt ^ AN_INV;
      frame <= slot_done && (slot == 2'd3);
    end
  end

endmodule

// File: tb/tb_cronometro_display_scan.sv
// Self-checking bench for cronometro_display_scan. Two instances share the
// inputs: one active-high, one active-low. A reference model derives the
// expected pins from the cycle position since reset and pushes them into a
// queue; a monitor pops one entry per cycle and compares both instances.
module tb_cronometro_display_scan;

  localparam int SLOT  = 20;
  localparam int BLANK = 4;
  localparam int BLINK = 3;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_su = 7'h06;
  logic [6:0] seg_st = 7'h5B;
  logic [6:0] seg_mu = 7'h4F;
  logic [6:0] seg_mt = 7'h66;
  logic       run = 1'b0;
  logic       lz_en = 1'b0;

  logic [6:0] seg_h, seg_l;
  logic       dp_h, dp_l;
  logic [3:0] an_h, an_l;
  logic       frame_h, frame_l;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         p = 0;
  int         done_slots = 0;
  logic [6:0] snap_m [4];

  cronometro_display_scan #(
    .SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .BLINK_SLOTS(BLINK), .ACT_LOW(1'b0)
  ) dut (
    .CLK_IN(clk), .RST(rst),
    .seg_su(seg_su), .seg_st(seg_st), .seg_mu(seg_mu), .seg_mt(seg_mt),
    .run(run), .lz_en(lz_en),
    .seg(seg_h), .dp(dp_h), .an(an_h), .frame(frame_h)
  );

  cronometro_display_scan #(
    .SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .BLINK_SLOTS(BLINK), .ACT_LOW(1'b1)
  ) dut_low (
    .CLK_IN(clk), .RST(rst),
    .seg_su(seg_su), .seg_st(seg_st), .seg_mu(seg_mu), .seg_mt(seg_mt),
    .run(run), .lz_en(lz_en),
    .seg(seg_l), .dp(dp_l), .an(an_l), .frame(frame_l)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at t=%0t: got %h, want %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] a_su, input logic [6:0] a_st,
                               input logic [6:0] a_mu, input logic [6:0] a_mt,
                               input logic a_run, input logic a_lz);
    seg_su = a_su;
    seg_st = a_st;
    seg_mu = a_mu;
    seg_mt = a_mt;
    run    = a_run;
    lz_en  = a_lz;
  endtask

  // Wait (bounded) until the scan sits at a given cycle offset inside a frame
  task automatic waitPos(input int target);
    int n;
    n = 0;
    while ((p % FRAME) != target && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if ((p % FRAME) != target) begin
      miscompares++;
      $display("[TB] FAIL wait_pos: position %0d, want %0d", p % FRAME, target);
    end
  endtask

  function automatic logic [6:0] patternFor(input int k);
    case (k)
      0: return seg_su;
      1: return seg_st;
      2: return seg_mu;
      default: return seg_mt;
    endcase
  endfunction

  // Reference model: p is the cycle index since reset release
  initial begin
    int   k;
    int   c;
    logic lit;
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        p = 0;
        done_slots = 0;
        exp_q.delete();
      end else begin
        k = (p / SLOT) % 4;
        c = p % SLOT;
        if (c == 0) snap_m[k] = patternFor(k);
        lit = ((done_slots / BLINK) % 2) == 0;
        e = '0;
        if (c >= BLANK) begin
          e.seg = snap_m[k];
          if (!(k == 3 && lz_en && snap_m[3] == 7'h3F)) e.an = 4'(1 << k);
          e.dp = (k == 2) && lit;
        end
        e.frame = (p % FRAME) == (FRAME - 1);
        exp_q.push_back(e);
        if (!run) done_slots = 0;
        else if (c == SLOT - 1) done_slots++;
        p++;
      end
    end
  end

  // Monitor: one expected entry per clock while out of reset
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL queue_underflow at t=%0t: got 0 entries, want 1", $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("an", {4'h0, an_h}, {4'h0, e.an});
          checkOutput("seg", {1'b0, seg_h}, {1'b0, e.seg});
          checkOutput("dp", {7'h0, dp_h}, {7'h0, e.dp});
          checkOutput("frame", {7'h0, frame_h}, {7'h0, e.frame});
          checkOutput("an_onehot", {7'h0, $onehot0(an_h)}, 8'h01);
          checkOutput("an_low", {4'h0, an_l}, {4'h0, 4'(~e.an)});
          checkOutput("seg_low", {1'b0, seg_l}, {1'b0, 7'(~e.seg)});
          checkOutput("dp_low", {7'h0, dp_l}, {7'h0, ~e.dp});
          checkOutput("frame_low", {7'h0, frame_l}, {7'h0, e.frame});
        end
      end
    end
  end

  // Scenario sequence followed by randomized traffic
  initial begin
    int n;
    applyStimulus(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_an", {4'h0, an_h}, 8'h00);
    checkOutput("reset_an_low", {4'h0, an_l}, 8'h0F);
    checkOutput("reset_seg_low", {1'b0, seg_l}, 8'h7F);
    checkOutput("reset_dp_low", {7'h0, dp_l}, 8'h01);
    #1 rst = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    waitPos(SLOT + 8);
    applyStimulus(7'h06, 7'h7D, 7'h4F, 7'h66, 1'b0, 1'b0);
    repeat (2 * FRAME) @(negedge clk);

    applyStimulus(7'h06, 7'h7D, 7'h4F, 7'h3F, 1'b0, 1'b1);
    repeat (2 * FRAME) @(negedge clk);
    applyStimulus(7'h06, 7'h7D, 7'h4F, 7'h3F, 1'b0, 1'b0);
    repeat (FRAME) @(negedge clk);

    applyStimulus(7'h06, 7'h7D, 7'h4F, 7'h66, 1'b1, 1'b0);
    repeat (30 * SLOT) @(negedge clk);
    run = 1'b0;
    repeat (FRAME) @(negedge clk);

    run = 1'b1;
    waitPos(2 * SLOT + 8);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_an", {4'h0, an_h}, 8'h00);
    checkOutput("async_rst_seg", {1'b0, seg_h}, 8'h00);
    checkOutput("async_rst_dp", {7'h0, dp_h}, 8'h00);
    checkOutput("async_rst_an_low", {4'h0, an_l}, 8'h0F);
    checkOutput("async_rst_seg_low", {1'b0, seg_l}, 8'h7F);
    checkOutput("async_rst_dp_low", {7'h0, dp_l}, 8'h01);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (an_h == 4'b0001) break;
    end
    checkOutput("first_an_latency", 8'(n), 8'd5);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0)
        applyStimulus(7'($urandom), 7'($urandom), 7'($urandom),
                      ($urandom_range(0, 1) == 1) ? 7'h3F : 7'($urandom),
                      run, 1'($urandom));
      if ($urandom_range(0, 199) == 0) run = ~run;
    end
    repeat (3) @(negedge clk);
    #1;
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #(100000 * 10);
    $display("[TB] FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
